tracker_dir_ctrl: RTL and testbench

Upstream stage of the servo PWM generator: converts paired light-sensor ADC samples into the DIR[1:0]/EN command consumed by the PWM block.
- Averages N sample pairs and compares them with hysteresis.
- Drives a timed move burst, then a settle window.
- Uses the PWM block's pulse-width feedback to stop at the mechanical end-stops.

---
 rtl/tracker_pkg.sv | 30 +++
 rtl/pair_averager.sv | 58 +++++
 rtl/tracker_dir_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tracker_dir_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared direction codes, FSM state type and end-stop check for the tracker direction controller.
package tracker_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    DECIDE = 2'd1,
    MOVE   = 2'd2,
    SETTLE = 2'd3
  } trkState_e;

  // CW is allowed only below the upper end-stop, CCW only above the lower one.
  function automatic logic limitOk(input logic [1:0]  dir,
                                   input logic [31:0] pulseWidth,
                                   input logic [31:0] minPw,
                                   input logic [31:0] maxPw);
    logic ok;
    ok = 1'b1;
    if (dir == DIR_CW) begin
      ok = (pulseWidth < maxPw);
    end else if (dir == DIR_CCW) begin
      ok = (pulseWidth > minPw);
    end
    return ok;
  endfunction

endpackage

// File: rtl/pair_averager.sv
// Accumulates 2^AVG_LOG2 sample pairs; done_o strobes combinationally on the completing sample.
module pair_averager
  import tracker_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [ADC_W-1:0] a_i,
  input  logic [ADC_W-1:0] b_i,
  output logic [ADC_W-1:0] avgA_o,
  output logic [ADC_W-1:0] avgB_o,
  output logic             done_o
);

  localparam int          SUM_W     = ADC_W + AVG_LOG2;
  localparam logic [31:0] LAST_PAIR = 32'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] sumA_q, sumA_d;
  logic [SUM_W-1:0] sumB_q, sumB_d;
  logic [31:0]      pairCnt_q, pairCnt_d;

  // Clear wins over a coincident sample so no partial sum survives a decision.
  always_comb begin
    sumA_d    = sumA_q;
    sumB_d    = sumB_q;
    pairCnt_d = pairCnt_q;
    if (clear_i) begin
      sumA_d    = '0;
      sumB_d    = '0;
      pairCnt_d = '0;
    end else if (valid_i) begin
      sumA_d    = sumA_q + {{AVG_LOG2{1'b0}}, a_i};
      sumB_d    = sumB_q + {{AVG_LOG2{1'b0}}, b_i};
      pairCnt_d = pairCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sumA_q    <= '0;
      sumB_q    <= '0;
      pairCnt_q <= '0;
    end else begin
      sumA_q    <= sumA_d;
      sumB_q    <= sumB_d;
      pairCnt_q <= pairCnt_d;
    end
  end

  assign done_o = valid_i && !clear_i && (pairCnt_q == LAST_PAIR);
  assign avgA_o = sumA_q[SUM_W-1:AVG_LOG2];
  assign avgB_o = sumB_q[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/tracker_dir_ctrl.sv
// Light-sensor tracker: averages ADC pairs, decides with hysteresis, drives timed DIR bursts.
// Optional manual jog path enabled by defining TRK_MANUAL_OVERRIDE_EN.
module tracker_dir_ctrl
  import tracker_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int AVG_LOG2   = 3,
  parameter int HYST       = 64,
  parameter int MOVE_CYC   = 200000,
  parameter int SETTLE_CYC = 100000,
  parameter int MIN_PW     = 500,
  parameter int MAX_PW     = 2500
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [ADC_W-1:0] adc_a_i,
  input  logic [ADC_W-1:0] adc_b_i,
  input  logic             adc_valid_i,
  input  logic [31:0]      pulse_width_i,
`ifdef TRK_MANUAL_OVERRIDE_EN
  input  logic             man_mode_i,
  input  logic             man_cw_i,
  input  logic             man_ccw_i,
`endif
  output logic [1:0]       dir_o,
  output logic             en_o,
  output logic [1:0]       state_o
);

  localparam logic [31:0] MOVE_LAST   = 32'(MOVE_CYC - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] MIN_PW_L    = 32'(MIN_PW);
  localparam logic [31:0] MAX_PW_L    = 32'(MAX_PW);

  trkState_e         state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic              en_q, en_d;
  logic [31:0]       timer_q, timer_d;

  logic              avgValid, avgClear, avgDone;
  logic [ADC_W-1:0]  avgA, avgB;
  logic signed [ADC_W:0] diff;
  logic [1:0]        reqDir;
  logic              manMode;
  logic [1:0]        manDir;

`ifdef TRK_MANUAL_OVERRIDE_EN
  assign manMode = man_mode_i;
  always_comb begin
    manDir = DIR_STOP;
    if (man_cw_i && !man_ccw_i) begin
      manDir = DIR_CW;
    end else if (man_ccw_i && !man_cw_i) begin
      manDir = DIR_CCW;
    end
  end
`else
  assign manMode = 1'b0;
  assign manDir  = DIR_STOP;
`endif

  assign avgValid = adc_valid_i && (state_q == ACQ) && !manMode;
  assign avgClear = (state_q == DECIDE) || manMode;

  pair_averager #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (avgClear),
    .valid_i (avgValid),
    .a_i     (adc_a_i),
    .b_i     (adc_b_i),
    .avgA_o  (avgA),
    .avgB_o  (avgB),
    .done_o  (avgDone)
  );

  // Dead band is inclusive: a difference of exactly +/-HYST does not move.
  assign diff = $signed({1'b0, avgA}) - $signed({1'b0, avgB});

  always_comb begin
    reqDir = DIR_STOP;
    if (int'(diff) > HYST) begin
      reqDir = DIR_CW;
    end else if (int'(diff) < -HYST) begin
      reqDir = DIR_CCW;
    end
  end

  // EN only ever rises; the PWM block reloads its widths on an EN fall.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    en_d    = en_q;
    timer_d = timer_q;
    if (manMode) begin
      state_d = ACQ;
      en_d    = 1'b1;
      timer_d = '0;
      dir_d   = limitOk(manDir, pulse_width_i, MIN_PW_L, MAX_PW_L) ? manDir : DIR_STOP;
    end else begin
      case (state_q)
        ACQ: begin
          dir_d = DIR_STOP;
          if (avgDone) begin
            state_d = DECIDE;
          end
        end
        DECIDE: begin
          en_d    = 1'b1;
          timer_d = '0;
          if ((reqDir != DIR_STOP) && limitOk(reqDir, pulse_width_i, MIN_PW_L, MAX_PW_L)) begin
            state_d = MOVE;
            dir_d   = reqDir;
          end else begin
            state_d = ACQ;
            dir_d   = DIR_STOP;
          end
        end
        MOVE: begin
          if (!limitOk(dir_q, pulse_width_i, MIN_PW_L, MAX_PW_L) || (timer_q == MOVE_LAST)) begin
            state_d = SETTLE;
            dir_d   = DIR_STOP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        SETTLE: begin
          dir_d = DIR_STOP;
          if (timer_q == SETTLE_LAST) begin
            state_d = ACQ;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: begin
          state_d = ACQ;
          dir_d   = DIR_STOP;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ACQ;
      dir_q   <= DIR_STOP;
      en_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      timer_q <= timer_d;
    end
  end

  assign dir_o   = dir_q;
  assign en_o    = en_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_tracker_dir_ctrl.sv
// Scoreboard bench for tracker_dir_ctrl: stimulus queues expected (state,dir,en,length) segments,
// a monitor compares each segment as the DUT outputs move on to the next one.
module tb_tracker_dir_ctrl;

  localparam int ADC_W      = 12;
  localparam int AVG_LOG2   = 2;
  localparam int HYST       = 64;
  localparam int MOVE_CYC   = 10;
  localparam int SETTLE_CYC = 5;
  localparam int MIN_PW     = 500;
  localparam int MAX_PW     = 2500;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ADC_W-1:0] adcA = '0;
  logic [ADC_W-1:0] adcB = '0;
  logic             adcValid = 1'b0;
  logic [31:0]      pulseWidth = 32'd1500;
  logic [1:0]       dir;
  logic             en;
  logic [1:0]       state;
`ifdef TRK_MANUAL_OVERRIDE_EN
  logic             manMode = 1'b0;
  logic             manCw = 1'b0;
  logic             manCcw = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0] st;
    logic [1:0] dr;
    logic       en;
    int         len;
  } seg_t;

  seg_t expQ[$];

  always #5 clk = ~clk;

  tracker_dir_ctrl #(
    .ADC_W      (ADC_W),
    .AVG_LOG2   (AVG_LOG2),
    .HYST       (HYST),
    .MOVE_CYC   (MOVE_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .MIN_PW     (MIN_PW),
    .MAX_PW     (MAX_PW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .adc_a_i       (adcA),
    .adc_b_i       (adcB),
    .adc_valid_i   (adcValid),
    .pulse_width_i (pulseWidth),
`ifdef TRK_MANUAL_OVERRIDE_EN
    .man_mode_i    (manMode),
    .man_cw_i      (manCw),
    .man_ccw_i     (manCcw),
`endif
    .dir_o         (dir),
    .en_o          (en),
    .state_o       (state)
  );

  // len < 0 means the segment length depends on stimulus pacing and is not checked.
  task automatic pushSeg(input logic [1:0] st, input logic [1:0] dr, input logic e, input int len);
    seg_t s;
    s.st = st;
    s.dr = dr;
    s.en = e;
    s.len = len;
    expQ.push_back(s);
  endtask

  task automatic applyStimulus(input int a, input int b);
    @(posedge clk);
    #1;
    adcA = ADC_W'(a);
    adcB = ADC_W'(b);
    adcValid = 1'b1;
    @(posedge clk);
    #1;
    adcValid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic waitMove();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (state == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("waitMove", 32'(found), 32'd1);
  endtask

  // Monitor: collapses the output stream into runs of identical (state,dir,en).
  initial begin : monitor
    logic [1:0] curSt;
    logic [1:0] curDr;
    logic       curEn;
    int         curLen;
    seg_t       e;
    curSt = 2'd0;
    curDr = 2'd0;
    curEn = 1'b0;
    curLen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        curSt = 2'd0;
        curDr = 2'd0;
        curEn = 1'b0;
        curLen = 0;
      end else if (state === curSt && dir === curDr && en === curEn) begin
        curLen++;
      end else begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL segment unexpected: got st=%0d dir=%0d en=%0d len=%0d, required none",
                   curSt, curDr, curEn, curLen);
        end else begin
          e = expQ.pop_front();
          if (e.st !== curSt || e.dr !== curDr || e.en !== curEn || (e.len >= 0 && e.len != curLen)) begin
            mismatched++;
            $display("[TB] FAIL segment: got st=%0d dir=%0d en=%0d len=%0d, required st=%0d dir=%0d en=%0d len=%0d",
                     curSt, curDr, curEn, curLen, e.st, e.dr, e.en, e.len);
          end
        end
        curSt = state;
        curDr = dir;
        curEn = en;
        curLen = 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    // Reset held with ADC_VALID toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      adcA = 12'd1000;
      adcB = 12'd900;
      adcValid = ~adcValid;
      checkOutput("rstDir", 32'(dir), 32'd0);
      checkOutput("rstEn", 32'(en), 32'd0);
      checkOutput("rstState", 32'(state), 32'd0);
    end
    adcValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idleState", 32'(state), 32'd0);
    checkOutput("idleDir", 32'(dir), 32'd0);
    checkOutput("idleEn", 32'(en), 32'd0);

    // CW move, junk samples during MOVE/SETTLE
    pulseWidth = 32'd1500;
    pushSeg(2'd0, 2'b00, 1'b0, -1);
    pushSeg(2'd1, 2'b00, 1'b0, 1);
    pushSeg(2'd2, 2'b01, 1'b1, MOVE_CYC);
    pushSeg(2'd3, 2'b00, 1'b1, SETTLE_CYC);
    for (int i = 0; i < 3; i++) applyStimulus(1000, 900);
    checkOutput("threePairsAcq", 32'(state), 32'd0);
    applyStimulus(1000, 900);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4000);
    repeat (25) @(posedge clk);

    // DIFF = +64: inside dead band
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(964, 900);
    repeat (5) @(posedge clk);

    // DIFF = -65: CCW
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    pushSeg(2'd2, 2'b10, 1'b1, MOVE_CYC);
    pushSeg(2'd3, 2'b00, 1'b1, SETTLE_CYC);
    for (int i = 0; i < 4; i++) applyStimulus(835, 900);
    repeat (25) @(posedge clk);

    // Truncating average: 4009 >> 2 = 1002, DIFF = 64
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    applyStimulus(1001, 938);
    applyStimulus(1002, 938);
    applyStimulus(1003, 938);
    applyStimulus(1003, 938);
    repeat (5) @(posedge clk);

    // CW request at the upper end-stop
    pulseWidth = 32'd2500;
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1000, 900);
    repeat (5) @(posedge clk);

    // CW burst reaching the end-stop on burst cycle 3
    pulseWidth = 32'd2490;
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    pushSeg(2'd2, 2'b01, 1'b1, 4);
    pushSeg(2'd3, 2'b00, 1'b1, SETTLE_CYC);
    for (int i = 0; i < 4; i++) applyStimulus(1000, 900);
    waitMove();
    repeat (3) @(posedge clk);
    #1;
    pulseWidth = 32'd2500;
    @(posedge clk);
    #1;
    checkOutput("limitDir", 32'(dir), 32'd0);
    checkOutput("limitState", 32'(state), 32'd3);
    repeat (20) @(posedge clk);
    #1;

    // CCW request at the lower end-stop
    pulseWidth = 32'd500;
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(835, 900);
    repeat (5) @(posedge clk);
    #1;
    pulseWidth = 32'd1500;

    // Reset on burst cycle 5
    pushSeg(2'd0, 2'b00, 1'b1, -1);
    pushSeg(2'd1, 2'b00, 1'b1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1000, 900);
    waitMove();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDir", 32'(dir), 32'd0);
    checkOutput("midRstEn", 32'(en), 32'd0);
    checkOutput("midRstState", 32'(state), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushSeg(2'd0, 2'b00, 1'b0, -1);
    pushSeg(2'd1, 2'b00, 1'b0, 1);
    pushSeg(2'd2, 2'b01, 1'b1, MOVE_CYC);
    pushSeg(2'd3, 2'b00, 1'b1, SETTLE_CYC);
    for (int i = 0; i < 3; i++) applyStimulus(1000, 900);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("freshAvgAcq", 32'(state), 32'd0);
    applyStimulus(1000, 900);
    repeat (25) @(posedge clk);
    #1;

    checkOutput("pendingSegments", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
